// File: rtl/m1_loader_pkg.sv
// m1_loader_pkg: shared types and constants for the M1 stream loader.
// Holds the loader state enum, the default bus widths and small helper
// functions used by the top level and the line packer.
package m1_loader_pkg;

  localparam int ADDR_W         = 16;
  localparam int LINE_W         = 128;
  localparam int BEAT_W         = 32;
  localparam int BEATS_PER_LINE = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Line address: base plus line index, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] index);
    return base + index;
  endfunction

  // 32-bit wrap-around accumulate used by the beat checksum.
  function automatic logic [31:0] sum32(input logic [31:0] acc,
                                        input logic [31:0] beat);
    return acc + beat;
  endfunction

endpackage

// File: rtl/line_packer.sv
// line_packer: gathers four stream beats into one M1 line.
// Beat n lands in lane n (beat 0 is the least significant lane). Lanes 0..2
// are held in registers; lane 3 is taken straight from the current beat so
// the completed line is available in the same cycle as the beat-3 handshake.
module line_packer #(
  parameter int BEAT_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              beat_take,
  input  logic [BEAT_W-1:0] beat_data,
  output logic              line_complete,
  output logic [LINE_W-1:0] line_data
);
  import m1_loader_pkg::*;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_LINE - 1);

  logic [1:0]        beat_count;
  logic [BEAT_W-1:0] lane0;
  logic [BEAT_W-1:0] lane1;
  logic [BEAT_W-1:0] lane2;

  assign line_complete = beat_take && (beat_count == LAST_BEAT);
  assign line_data     = {beat_data, lane2, lane1, lane0};

  // Beat counter and lane registers: a clear discards any partial line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_count <= 2'd0;
      lane0      <= {BEAT_W{1'b0}};
      lane1      <= {BEAT_W{1'b0}};
      lane2      <= {BEAT_W{1'b0}};
    end else if (clear) begin
      beat_count <= 2'd0;
      lane0      <= {BEAT_W{1'b0}};
      lane1      <= {BEAT_W{1'b0}};
      lane2      <= {BEAT_W{1'b0}};
    end else if (beat_take) begin
      beat_count <= beat_count + 2'd1;
      case (beat_count)
        2'd0:    lane0 <= beat_data;
        2'd1:    lane1 <= beat_data;
        2'd2:    lane2 <= beat_data;
        default: lane2 <= lane2;
      endcase
    end else begin
      beat_count <= beat_count;
    end
  end

endmodule

// File: rtl/m1_stream_loader.sv
// m1_stream_loader: packs a 32-bit valid/ready stream into 128-bit lines,
// writes them into M1 starting at base_addr, then raises start to the core
// until done. Optional feature macro: M1_LOADER_CHECKSUM_EN (running 32-bit
// sum of accepted beats on checksum; tied to zero when undefined).
module m1_stream_loader #(
  parameter int ADDR_W = m1_loader_pkg::ADDR_W,
  parameter int LINE_W = m1_loader_pkg::LINE_W,
  parameter int BEAT_W = m1_loader_pkg::BEAT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_lines,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BEAT_W-1:0] s_data,
  output logic              M1_WriteEnable,
  output logic [ADDR_W-1:0] M1_WriteAddress,
  output logic [LINE_W-1:0] M1_WriteBus,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic [31:0]       checksum
);
  import m1_loader_pkg::*;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] lines_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] line_count;
  logic              take;
  logic              load_accept;
  logic              last_line;
  logic              line_complete;
  logic [LINE_W-1:0] line_data;

  // A beat is accepted only while s_ready (high solely in FILL) is asserted.
  assign take        = s_valid && s_ready;
  assign load_accept = (state == ST_IDLE) && load_req;
  assign last_line   = (line_count == (lines_q - ADDR_W'(1)));

  line_packer #(
    .BEAT_W (BEAT_W),
    .LINE_W (LINE_W)
  ) u_packer (
    .clock         (clock),
    .reset         (reset),
    .clear         (load_accept),
    .beat_take     (take),
    .beat_data     (s_data),
    .line_complete (line_complete),
    .line_data     (line_data)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a zero-line load goes straight to RUN.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (load_req) begin
          if (load_lines == {ADDR_W{1'b0}}) begin
            next_state = ST_RUN;
          end else begin
            next_state = ST_FILL;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (line_complete && last_line) begin
          next_state = ST_FLUSH;
        end else begin
          next_state = ST_FILL;
        end
      end
      ST_FLUSH: begin
        next_state = ST_RUN;
      end
      ST_RUN: begin
        if (done) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_RUN;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Load parameters and line counter, captured when a load is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lines_q    <= {ADDR_W{1'b0}};
      base_q     <= {ADDR_W{1'b0}};
      line_count <= {ADDR_W{1'b0}};
    end else if (load_accept) begin
      lines_q    <= load_lines;
      base_q     <= base_addr;
      line_count <= {ADDR_W{1'b0}};
    end else if (line_complete) begin
      line_count <= line_count + ADDR_W'(1);
    end else begin
      line_count <= line_count;
    end
  end

  // Registered outputs, derived from the upcoming state so they align with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_ready         <= 1'b0;
      start           <= 1'b0;
      busy            <= 1'b0;
      M1_WriteEnable  <= 1'b0;
      M1_WriteAddress <= {ADDR_W{1'b0}};
      M1_WriteBus     <= {LINE_W{1'b0}};
    end else begin
      s_ready        <= (next_state == ST_FILL);
      start          <= (next_state == ST_RUN);
      busy           <= (next_state != ST_IDLE);
      M1_WriteEnable <= line_complete;
      if (line_complete) begin
        M1_WriteAddress <= line_addr(base_q, line_count);
        M1_WriteBus     <= line_data;
      end else begin
        M1_WriteAddress <= M1_WriteAddress;
        M1_WriteBus     <= M1_WriteBus;
      end
    end
  end

`ifdef M1_LOADER_CHECKSUM_EN
  logic [31:0] beat_sum;

  // Beat checksum: cleared on an accepted load, held through RUN and IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_sum <= 32'd0;
    end else if (load_accept) begin
      beat_sum <= 32'd0;
    end else if (take) begin
      beat_sum <= sum32(beat_sum, 32'(s_data));
    end else begin
      beat_sum <= beat_sum;
    end
  end

  assign checksum = beat_sum;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: doc/m1_stream_loader.md
# m1_stream_loader

Upstream feeder for the processing core. Accepts a 32-bit valid/ready input stream, packs four beats into each 128-bit line, and writes the lines into the M1 SRAM through its write port (`sram_2R1W`, 16-bit address, 128-bit data). When the programmed number of lines has landed, it raises `start` to the core and holds it until the core reports `done`. This replaces the simulation-only `$readmemh` preload of M1.

## Interface
Parameters:
- `ADDR_W`, 16: M1 address width.
- `LINE_W`, 128: M1 data width.
- `BEAT_W`, 32: input stream width. `LINE_W / BEAT_W` must equal 4.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `load_req`, in, 1: one-cycle pulse that begins a load. Sampled only in IDLE.
- `load_lines`, in, ADDR_W: number of lines to write. Sampled with `load_req`.
- `base_addr`, in, ADDR_W: first M1 address. Sampled with `load_req`.
- `s_valid`, in, 1: input beat valid.
- `s_ready`, out, 1: loader can accept a beat.
- `s_data`, in, BEAT_W: input beat.
- `M1_WriteEnable`, out, 1: M1 write strobe.
- `M1_WriteAddress`, out, ADDR_W: M1 write address.
- `M1_WriteBus`, out, LINE_W: M1 write data.
- `start`, out, 1: go signal to the core, level.
- `done`, in, 1: core completion.
- `busy`, out, 1: high in any state other than IDLE.
- `checksum`, out, 32: running beat sum. See Configuration.

## Operation
- States: IDLE, FILL, FLUSH, RUN.
- **IDLE**
  - On `load_req`, latch `load_lines` and `base_addr`, and clear the beat counter (2 bits) and line counter (ADDR_W bits).
  - Go to FILL if `load_lines` != 0.
  - Go to RUN if `load_lines` == 0. No writes occur in this case.
- **FILL**
  - A handshake occurs when `s_valid && s_ready`.
  - Beat n (0..3) of a line goes into bits [32n+31:32n]; beat 0 is the least significant lane.
  - On a beat-3 handshake, the assembled line is registered onto `M1_WriteBus`, `M1_WriteAddress = base + line_count` (mod 2^16, so the address wraps past 0xFFFF), and `M1_WriteEnable` pulses for exactly one cycle. The line counter then increments.
  - A beat-3 handshake on the final line (`line_count == load_lines - 1`) moves the state to FLUSH.
- **FLUSH**
  - Lasts one cycle, during which the final write is on the bus.
  - Then go to RUN.
- **RUN**
  - `start` = 1.
  - When `done` is sampled high, go to IDLE and clear `start`.
- `load_req` outside IDLE is ignored.
- `s_data` is ignored whenever no handshake occurs.
- The M1 write port is never back-pressured, so consecutive lines may be written on back-to-back cycles.

## Timing
- All outputs are registered.
- Reset values:
  - `s_ready` = 0, `M1_WriteEnable` = 0, `M1_WriteAddress` = 0, `M1_WriteBus` = 0.
  - `start` = 0, `busy` = 0, `checksum` = 0, state = IDLE.
- `s_ready` is 1 from the cycle after entering FILL through the cycle of the final beat-3 handshake, and 0 in the following cycle.
- Write latency: `M1_WriteEnable` is high in the cycle after the beat-3 handshake, and the SRAM commits at the end of that cycle.
- `start` rises one cycle after the final `M1_WriteEnable` pulse, so M1 is fully written before the core sees `start`.
- With `load_lines == 0`, `start` rises one cycle after `load_req`.
- `start` falls one cycle after `done` is sampled. `busy` falls in the same cycle.
- If `done` is high on RUN entry, RUN lasts exactly one cycle.
- Reset mid-operation: a partial line is discarded, any pending write is dropped, and state returns to IDLE. M1 contents already written remain as-is.
- Peak throughput: 1 beat/cycle, i.e. 1 line per 4 cycles.

## Configuration
- Macro `M1_LOADER_CHECKSUM_EN`.
- **Defined:** `checksum` accumulates a 32-bit mod-2^32 sum of every accepted beat. It is cleared on `load_req` in IDLE and holds its value through RUN and IDLE until the next `load_req`.
- **Undefined:** `checksum` is tied to 0 and no accumulator logic is built.

## Structure
- Package `m1_loader_pkg` holds:
  - the state enum (IDLE, FILL, FLUSH, RUN);
  - constants `ADDR_W`, `LINE_W`, `BEAT_W`;
  - `BEATS_PER_LINE = 4`.
- Sub-module `line_packer` contains the 4-lane assembly register and beat counter. It reports line-complete, and the top-level FSM owns the addressing and write strobe.

## Test plan
- **Normal load:** `load_lines=2`, `base_addr=0x0010`, beats 0x00000001..0x00000008 with no gaps. Expect writes:
  - 0x0010 ← 0x00000004_00000003_00000002_00000001
  - 0x0011 ← 0x00000008_00000007_00000006_00000005
  
  Then `start` rises one cycle after the second `M1_WriteEnable`. `checksum` = 0x24 when the macro is defined.
- **Back-pressure gaps:** `s_valid` toggled 1/0 across the same 8 beats. Expect identical writes, and `M1_WriteEnable` high for exactly 2 cycles total.
- **Address wrap:** `base_addr=0xFFFF`, `load_lines=2`. Expect writes to 0xFFFF and then 0x0000.
- **Zero lines:** `load_lines=0`. Expect no `M1_WriteEnable`, `s_ready` stays 0, and `start` rises one cycle after `load_req`.
- **Done handshake:** in RUN, pulse `done` for one cycle. Expect `start` and `busy` to fall the next cycle, and a second `load_req` in that same cycle to be ignored.
- **Reset mid-line:** assert `reset` after 2 beats of line 0. Expect all outputs at reset values immediately, no write, and a fresh `load_req` to pack from beat 0.
